// File: rtl/drive_pkg.sv
// Shared encodings for the drive sequencer: motor commands, command codes,
// FSM states, mode selection and indicator-light decode.
package drive_pkg;

    localparam logic [3:0] MS_STOP    = 4'b0000;
    localparam logic [3:0] MS_FORWARD = 4'b0001;
    localparam logic [3:0] MS_BACK    = 4'b0010;
    localparam logic [3:0] MS_LEFT    = 4'b0100;
    localparam logic [3:0] MS_RIGHT   = 4'b1000;

    localparam logic [2:0] CMD_STOP  = 3'b000;
    localparam logic [2:0] CMD_FWD   = 3'b001;
    localparam logic [2:0] CMD_LEFT  = 3'b010;
    localparam logic [2:0] CMD_RIGHT = 3'b011;
    localparam logic [2:0] CMD_UTURN = 3'b100;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TURN   = 2'd1;
    localparam logic [1:0] ST_COOL   = 2'd2;
    localparam logic [1:0] ST_CRUISE = 2'd3;

    localparam logic [1:0] GS_MANUAL = 2'b00;
    localparam logic [1:0] GS_SEMI   = 2'b01;
    localparam logic [1:0] GS_AUTO   = 2'b10;
    localparam logic [1:0] GS_RSVD   = 2'b11;

    typedef struct packed {
        logic right;
        logic left;
        logic back;
        logic fwd;
    } lights_t;

    // Only the four legal one-hot motor commands light anything.
    function automatic lights_t decode_lights(input logic [3:0] ms);
        lights_t l;
        l = '0;
        case (ms)
            MS_FORWARD: l.fwd   = 1'b1;
            MS_BACK:    l.back  = 1'b1;
            MS_LEFT:    l.left  = 1'b1;
            MS_RIGHT:   l.right = 1'b1;
            default:    l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/drive_sequencer_tick_gen.sv
// Free-running tick divider: one-cycle pulse every TICK_CYCLES clocks,
// restarted from zero by clr so timed states begin on a full tick period.
module tick_gen #(
    parameter int TICK_CYCLES = 2_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/drive_sequencer.sv
// Motor-command owner: selects manual/semi/auto source and runs each accepted
// command as turn -> forward cooldown -> cruise-to-crossroad.
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int TICK_CYCLES = 2_000_000,
    parameter int TURN_TICKS  = 200,
    parameter int UTURN_TICKS = 400,
    parameter int COOL_TICKS  = 50
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [3:0] detector,
    input  logic [3:0] manual_cmd,
    input  logic       semi_valid,
    input  logic [2:0] semi_cmd,
    input  logic       auto_valid,
    input  logic [2:0] auto_cmd,
    output logic       semi_ack,
    output logic       auto_ack,
    output logic [3:0] moving_state,
    output logic       arrive,
    output logic       busy,
    output logic       move_forward_light,
    output logic       move_backward_light,
    output logic       turn_left_light,
    output logic       turn_right_light
);
    localparam logic [10:0] TURN_T  = 11'(TURN_TICKS);
    localparam logic [10:0] UTURN_T = 11'(UTURN_TICKS);
    localparam logic [10:0] COOL_T  = 11'(COOL_TICKS);

    logic [1:0]  state_q, state_d;
    logic [3:0]  ms_d;
    logic [10:0] tcnt_q, target_q, target_d;
    logic [2:0]  mode_q;
    logic        arrive_d, accept, active, mode_chg, crossroad;
    logic        sel_valid, sel_ack, tick, clr;
    logic [2:0]  sel_cmd;
    logic        det_unused;
    lights_t     lights_d;

    assign det_unused = detector[3];
    assign crossroad  = detector[0] | ~detector[1] | ~detector[2];
    assign active     = power && (global_state == GS_SEMI || global_state == GS_AUTO);
    assign mode_chg   = {power, global_state} != mode_q;
    assign sel_valid  = (global_state == GS_SEMI) ? semi_valid : auto_valid;
    assign sel_ack    = (global_state == GS_SEMI) ? semi_ack   : auto_ack;
    assign sel_cmd    = (global_state == GS_SEMI) ? semi_cmd   : auto_cmd;
    assign accept     = active && !mode_chg && state_q == ST_IDLE && sel_valid && !sel_ack;
    assign clr        = (state_d != state_q);
    assign lights_d   = decode_lights(ms_d);

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (clr),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        ms_d     = moving_state;
        target_d = target_q;
        arrive_d = 1'b0;
        if (!active) begin
            state_d = ST_IDLE;
            ms_d    = (power && global_state == GS_MANUAL) ? manual_cmd : MS_STOP;
        end else if (mode_chg) begin
            state_d = ST_IDLE;
            ms_d    = MS_STOP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ms_d = MS_STOP;
                    if (accept) begin
                        case (sel_cmd)
                            CMD_FWD:   begin state_d = ST_COOL; ms_d = MS_FORWARD; end
                            CMD_LEFT:  begin state_d = ST_TURN; ms_d = MS_LEFT;  target_d = TURN_T;  end
                            CMD_RIGHT: begin state_d = ST_TURN; ms_d = MS_RIGHT; target_d = TURN_T;  end
                            CMD_UTURN: begin state_d = ST_TURN; ms_d = MS_RIGHT; target_d = UTURN_T; end
                            default:   state_d = ST_IDLE;
                        endcase
                    end
                end
                // Leave on the tick that completes the target count.
                ST_TURN: if (tick && tcnt_q == target_q - 11'd1) begin
                    state_d = ST_COOL;
                    ms_d    = MS_FORWARD;
                end
                ST_COOL: if (tick && tcnt_q == COOL_T - 11'd1) state_d = ST_CRUISE;
                ST_CRUISE: if (crossroad) begin
                    state_d  = ST_IDLE;
                    ms_d     = MS_STOP;
                    arrive_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    ms_d    = MS_STOP;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q             <= ST_IDLE;
            tcnt_q              <= '0;
            target_q            <= '0;
            mode_q              <= '0;
            moving_state        <= MS_STOP;
            semi_ack            <= 1'b0;
            auto_ack            <= 1'b0;
            arrive              <= 1'b0;
            busy                <= 1'b0;
            move_forward_light  <= 1'b0;
            move_backward_light <= 1'b0;
            turn_left_light     <= 1'b0;
            turn_right_light    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            mode_q   <= {power, global_state};
            if (clr)
                tcnt_q <= '0;
            else if (tick && (state_q == ST_TURN || state_q == ST_COOL))
                tcnt_q <= tcnt_q + 11'd1;
            moving_state        <= ms_d;
            semi_ack            <= accept && global_state == GS_SEMI;
            auto_ack            <= accept && global_state == GS_AUTO;
            arrive              <= arrive_d;
            busy                <= (state_d != ST_IDLE);
            move_forward_light  <= lights_d.fwd;
            move_backward_light <= lights_d.back;
            turn_left_light     <= lights_d.left;
            turn_right_light    <= lights_d.right;
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: stimulus queues expected ack/arrive
// events, a monitor pops and compares them whenever the DUT pulses one.
module tb_drive_sequencer;
    localparam int TC = 4;
    localparam int TT = 3;
    localparam int UT = 6;
    localparam int CT = 2;
    localparam logic [2:0] K_SEMI = 3'b001;
    localparam logic [2:0] K_AUTO = 3'b010;
    localparam logic [2:0] K_ARR  = 3'b100;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       power = 1'b0;
    logic [1:0] global_state = 2'b00;
    logic [3:0] detector = 4'b0110;
    logic [3:0] manual_cmd = 4'b0000;
    logic       semi_valid = 1'b0;
    logic [2:0] semi_cmd = 3'b000;
    logic       auto_valid = 1'b0;
    logic [2:0] auto_cmd = 3'b000;
    logic       semi_ack, auto_ack, arrive, busy;
    logic [3:0] moving_state;
    logic       move_forward_light, move_backward_light, turn_left_light, turn_right_light;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] ms;
    } ev_t;
    ev_t exp_q[$];

    drive_sequencer #(.TICK_CYCLES(TC), .TURN_TICKS(TT), .UTURN_TICKS(UT), .COOL_TICKS(CT)) dut (
        .sys_clk             (sys_clk),
        .rst                 (rst),
        .power               (power),
        .global_state        (global_state),
        .detector            (detector),
        .manual_cmd          (manual_cmd),
        .semi_valid          (semi_valid),
        .semi_cmd            (semi_cmd),
        .auto_valid          (auto_valid),
        .auto_cmd            (auto_cmd),
        .semi_ack            (semi_ack),
        .auto_ack            (auto_ack),
        .moving_state        (moving_state),
        .arrive              (arrive),
        .busy                (busy),
        .move_forward_light  (move_forward_light),
        .move_backward_light (move_backward_light),
        .turn_left_light     (turn_left_light),
        .turn_right_light    (turn_right_light)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic run(input logic [3:0] ms, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            chk(name, {28'd0, moving_state}, {28'd0, ms});
            @(negedge sys_clk);
        end
    endtask

    // Scoreboard monitor: every ack/arrive pulse must match the next expected event.
    always @(negedge sys_clk) begin : monitor
        ev_t e;
        if (rst && (semi_ack || auto_ack || arrive)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'd0, arrive, auto_ack, semi_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {29'd0, arrive, auto_ack, semi_ack}, {29'd0, e.kind});
                chk("event_ms", {28'd0, moving_state}, {28'd0, e.ms});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        power = 1'b1;
        global_state = 2'b01;
        cyc(2);
        chk("reset_ms", {28'd0, moving_state}, 32'd0);
        chk("reset_flags", {26'd0, semi_ack, auto_ack, arrive, busy, move_forward_light, turn_left_light}, 32'd0);
        rst = 1'b1;
        cyc(2);

        // Semi LEFT: 12 cycles LEFT, 8 COOL, cruise until crossroad.
        semi_cmd = 3'b010; semi_valid = 1'b1;
        exp_q.push_back('{K_SEMI, 4'b0100});
        cyc(1);
        semi_valid = 1'b0;
        chk("left_busy", {31'd0, busy}, 32'd1);
        chk("left_light", {31'd0, turn_left_light}, 32'd1);
        run(4'b0100, 12, "left_turn");
        run(4'b0001, 8, "left_cool");
        run(4'b0001, 3, "left_cruise");
        detector = 4'b0111;
        exp_q.push_back('{K_ARR, 4'b0000});
        cyc(1);
        detector = 4'b0110;
        chk("left_stop", {28'd0, moving_state}, 32'd0);
        chk("left_idle", {31'd0, busy}, 32'd0);

        // Auto UTURN with semi_valid also high: only the auto source is served.
        global_state = 2'b10;
        cyc(2);
        auto_cmd = 3'b100; auto_valid = 1'b1;
        semi_cmd = 3'b001; semi_valid = 1'b1;
        exp_q.push_back('{K_AUTO, 4'b1000});
        cyc(1);
        auto_valid = 1'b0;
        chk("uturn_light", {31'd0, turn_right_light}, 32'd1);
        run(4'b1000, 24, "uturn_turn");
        run(4'b0001, 8, "uturn_cool");
        run(4'b0001, 2, "uturn_cruise");
        semi_valid = 1'b0;
        detector = 4'b0100;
        exp_q.push_back('{K_ARR, 4'b0000});
        cyc(1);
        detector = 4'b0110;
        chk("uturn_stop", {28'd0, moving_state}, 32'd0);

        // STOP held valid for 5 edges: accepted on edges 1, 3, 5.
        global_state = 2'b01;
        cyc(2);
        semi_cmd = 3'b000; semi_valid = 1'b1;
        repeat (3) exp_q.push_back('{K_SEMI, 4'b0000});
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stop_busy", {31'd0, busy}, 32'd0);
            chk("stop_ms", {28'd0, moving_state}, 32'd0);
        end
        semi_valid = 1'b0;
        cyc(2);
        chk("stop_acks_consumed", exp_q.size(), 32'd0);

        // Mode abort during TURN into manual.
        semi_cmd = 3'b011; semi_valid = 1'b1;
        exp_q.push_back('{K_SEMI, 4'b1000});
        cyc(1);
        semi_valid = 1'b0;
        run(4'b1000, 5, "abort_turn");
        global_state = 2'b00; manual_cmd = 4'b0010;
        cyc(1);
        chk("abort_ms", {28'd0, moving_state}, 32'h2);
        chk("abort_lights", {28'd0, turn_right_light, turn_left_light, move_backward_light, move_forward_light}, 32'h2);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        manual_cmd = 4'b1000;
        cyc(1);
        chk("manual_right_ms", {28'd0, moving_state}, 32'h8);
        chk("manual_right_lights", {28'd0, turn_right_light, turn_left_light, move_backward_light, move_forward_light}, 32'h8);
        manual_cmd = 4'b0011;
        cyc(1);
        chk("manual_bad_ms", {28'd0, moving_state}, 32'h3);
        chk("manual_bad_lights", {28'd0, turn_right_light, turn_left_light, move_backward_light, move_forward_light}, 32'h0);

        // Power drop during COOL.
        manual_cmd = 4'b0000; global_state = 2'b01;
        cyc(2);
        semi_cmd = 3'b001; semi_valid = 1'b1;
        exp_q.push_back('{K_SEMI, 4'b0001});
        cyc(1);
        semi_valid = 1'b0;
        run(4'b0001, 3, "fwd_cool");
        chk("fwd_busy", {31'd0, busy}, 32'd1);
        power = 1'b0;
        cyc(1);
        chk("power_ms", {28'd0, moving_state}, 32'd0);
        chk("power_busy", {31'd0, busy}, 32'd0);
        chk("power_light", {31'd0, move_forward_light}, 32'd0);
        power = 1'b1;
        cyc(2);

        // Asynchronous reset mid-cycle during CRUISE.
        semi_cmd = 3'b001; semi_valid = 1'b1;
        exp_q.push_back('{K_SEMI, 4'b0001});
        cyc(1);
        semi_valid = 1'b0;
        run(4'b0001, 8, "cool2");
        run(4'b0001, 2, "cruise2");
        chk("cruise2_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ms", {28'd0, moving_state}, 32'd0);
        chk("async_rst_flags", {25'd0, semi_ack, auto_ack, arrive, busy,
            move_forward_light, move_backward_light, turn_left_light}, 32'd0);
        @(negedge sys_clk);
        rst = 1'b1;
        cyc(2);

        // Reserved mode ignores auto_valid.
        global_state = 2'b11; auto_cmd = 3'b001; auto_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("rsvd_ms", {28'd0, moving_state}, 32'd0);
            chk("rsvd_busy_ack", {29'd0, busy, semi_ack, auto_ack}, 32'd0);
        end
        auto_valid = 1'b0;
        cyc(2);
        chk("all_events_seen", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Owns the car's motor command (moving_state) and shares it between the manual switches, the semi-auto crossroad logic and the auto-navigation logic. It selects the source from global_state and accepts discrete commands through a valid/ack handshake. Each command is executed as a timed sequence: turn, then a forward cooldown, then cruise until the next crossroad. It drives the direction indicator lights.

Parameters:
TICK_CYCLES, 2_000_000, sys_clk cycles per 20 ms tick (100 MHz clock).
TURN_TICKS, 200, ticks for a 90-degree turn.
UTURN_TICKS, 400, ticks for a U-turn (executed as a right turn).
COOL_TICKS, 50, forward ticks after a turn or go-straight, during which the detector is ignored.

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
power  in  1  car powered
global_state  in  2  mode: 00 manual, 01 semi-auto, 10 auto, 11 reserved
detector  in  4  line/obstacle sensors; crossroad = detector[0] | ~detector[1] | ~detector[2]
manual_cmd  in  4  moving_state requested in manual mode
semi_valid  in  1  semi-auto command valid
semi_cmd  in  3  semi-auto command code
auto_valid  in  1  auto command valid
auto_cmd  in  3  auto command code
semi_ack  out  1  one-cycle pulse: semi command accepted
auto_ack  out  1  one-cycle pulse: auto command accepted
moving_state  out  4  motor command: 0000 STOP, 0001 FORWARD, 0010 BACK, 0100 LEFT, 1000 RIGHT
arrive  out  1  one-cycle pulse: crossroad reached, car stopped
busy  out  1  FSM not in IDLE
move_forward_light, move_backward_light, turn_left_light, turn_right_light  out  1 each  registered decode of moving_state

Behaviour:
- All outputs are registered. Reset value of every output is 0: moving_state = STOP, FSM = IDLE, tick counters cleared.
- Command codes: 000 STOP, 001 FWD, 010 LEFT, 011 RIGHT, 100 UTURN. Codes 101–111 are treated as STOP.
- Active mode = semi (01) or auto (10) with power=1. Only the matching source's valid is sampled; the other source's ack stays 0.
- power=0 or global_state=11: FSM forced to IDLE, moving_state=STOP on the next edge; no ack, no arrive.
- Manual mode (00, power=1): FSM forced to IDLE; moving_state <= manual_cmd, one cycle latency.
- Mode change during any state: abort to IDLE, moving_state=STOP on the next edge; no arrive pulse.
- Handshake: a command is accepted when the FSM is in IDLE, the selected valid=1 and that source's ack=0. The ack pulses in the cycle after the sampling edge. The source must drop valid after seeing ack; a valid still high in the ack cycle is not re-accepted.
- FSM states:
  - IDLE: moving_state STOP. Transitions on an accepted command:
    - STOP → stays IDLE (acked).
    - FWD → COOL, FORWARD.
    - LEFT → TURN, target TURN_TICKS, LEFT.
    - RIGHT → TURN, target TURN_TICKS, RIGHT.
    - UTURN → TURN, target UTURN_TICKS, RIGHT.
  - TURN: counts ticks. At count == target → COOL, FORWARD.
  - COOL: FORWARD, detector ignored. At COOL_TICKS ticks → CRUISE.
  - CRUISE: FORWARD until crossroad=1, then → IDLE, STOP, arrive pulse in the same update.
- Tick generator is cleared on every state entry. Each timed state therefore lasts exactly target*TICK_CYCLES cycles. Tick counter width is 11 bits and must not wrap below UTURN_TICKS.
- Crossroad already true on entry to CRUISE: return to IDLE on the next edge.
- Lights are decoded from moving_state. Exactly one light is lit for FORWARD, BACK, LEFT or RIGHT; none for STOP or any other value.

Decomposition:
- Package drive_pkg:
  - moving_state encodings STOP, FORWARD, BACK, LEFT, RIGHT
  - command codes
  - FSM state encodings IDLE, TURN, COOL, CRUISE
  - global_state encodings
- Sub-module tick_gen (sys_clk, rst, clr, tick): one-cycle pulse every TICK_CYCLES cycles; restarts from zero on clr.

Test Plan:
(TICK_CYCLES=4, TURN_TICKS=3, UTURN_TICKS=6, COOL_TICKS=2; non-crossroad detector = 4'b0110)
- Semi LEFT: gs=01, semi_valid with cmd=010 → semi_ack one cycle later; moving_state=0100 for 12 cycles, then 0001 for 8 cycles, then 0001 until detector=4'b0111; then arrive pulse and moving_state=0000 on the next edge.
- Auto UTURN with both valids high: gs=10, auto_cmd=100, semi_valid=1 → only auto_ack; moving_state=1000 for 24 cycles, then COOL; semi_ack never asserted.
- STOP held valid: semi_cmd=000 with valid held for 5 cycles → exactly one semi_ack per acceptance window (ack cycle blocks re-accept); busy stays 0; moving_state=0000.
- Mode abort: during TURN, gs 01→00 with manual_cmd=0010 → moving_state=0010 and move_backward_light=1 the next cycle; no arrive pulse.
- Power/reset: power=0 mid-COOL → moving_state=0000 next edge. rst=0 asserted mid-cycle during CRUISE → all outputs 0 immediately, without waiting for a clock edge.
- Reserved mode: gs=11 with auto_valid=1 → no ack, moving_state=0000, busy=0.
